cross_light_ctrl: RTL and testbench

Cross-street signal controller for the liveness traffic-light benchmark. It watches the main-direction light and serves the cross direction only while the main direction is red. Each served phase is all-red clearance, then cross green (with an optional pedestrian walk), then cross yellow. Any overlap with a non-red main light is latched as a sticky conflict, and the block locks to red.

---
 rtl/cross_light_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cross_light_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_light_ctrl.sv
// cross_light_ctrl: cross-street signal controller.
// Serves one cross phase (all-red clearance, green with optional pedestrian walk, yellow)
// per main-direction red interval. Any overlap of an active cross phase with a non-red
// main light latches a sticky conflict and locks the cross direction to red until reset.
//
// Ports:
//   clk             in   sole clock, posedge
//   reset_n         in   asynchronous active-low reset
//   main_light      in   [1:0] main light: 0 red, 1 green, 2 yellow, 3 illegal (not red)
//   ped_req         in   pedestrian request, level-sampled
//   cross_light     out  [1:0] cross light, same encoding (0/1/2 only)
//   cross_time_left out  [7:0] current phase counter
//   walk            out  pedestrian walk indication
//   ped_pending     out  latched, unserved pedestrian request
//   conflict        out  sticky safety violation
module cross_light_ctrl #(
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned CROSS_GREEN  = 40,
  parameter int unsigned CROSS_YELLOW = 5,
  parameter int unsigned WALK_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] main_light,
  input  logic       ped_req,
  output logic [1:0] cross_light,
  output logic [7:0] cross_time_left,
  output logic       walk,
  output logic       ped_pending,
  output logic       conflict
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_CLEAR  = 2'd1,
    S_GREEN  = 2'd2,
    S_YELLOW = 2'd3
  } state_t;

  localparam logic [7:0] ClearLoad  = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] GreenLoad  = 8'(CROSS_GREEN - 1);
  localparam logic [7:0] YellowLoad = 8'(CROSS_YELLOW - 1);
  localparam logic [7:0] WalkLoad   = 8'(WALK_CYCLES);

  state_t     r_state, w_state_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [7:0] r_walk_cnt, w_walk_cnt_d;
  logic       r_armed, w_armed_d;
  logic       r_ped_pending, w_ped_pending_d;
  logic       r_conflict, w_conflict_d;
  logic       r_walk, w_walk_d;
  logic [1:0] r_cross_light, w_cross_light_d;

  logic w_main_nonred;
  logic w_hit;    // active cross phase overlaps a non-red main light
  logic w_serve;  // clear -> green transition this cycle

  assign w_main_nonred = (main_light != 2'd0);
  assign w_hit         = (r_state != S_RED) && w_main_nonred;

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_walk_cnt_d    = (r_walk_cnt != 8'd0) ? r_walk_cnt - 8'd1 : 8'd0;
    w_armed_d       = r_armed | w_main_nonred;
    w_ped_pending_d = r_ped_pending | ped_req;
    w_conflict_d    = r_conflict;
    w_serve         = 1'b0;

    unique case (r_state)
      S_RED: begin
        w_cnt_d = 8'd0;
        if (!w_main_nonred && r_armed && !r_conflict) begin
          w_state_d = S_CLEAR;
          w_cnt_d   = ClearLoad;
          w_armed_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (r_cnt != 8'd0) begin
          w_cnt_d = r_cnt - 8'd1;
        end else begin
          w_state_d = S_GREEN;
          w_cnt_d   = GreenLoad;
          w_serve   = 1'b1;
        end
      end
      S_GREEN: begin
        if (r_cnt != 8'd0) begin
          w_cnt_d = r_cnt - 8'd1;
        end else begin
          w_state_d = S_YELLOW;
          w_cnt_d   = YellowLoad;
        end
      end
      S_YELLOW: begin
        if (r_cnt != 8'd0) begin
          w_cnt_d = r_cnt - 8'd1;
        end else begin
          w_state_d = S_RED;
          w_cnt_d   = 8'd0;
        end
      end
      default: begin
        w_state_d = S_RED;
        w_cnt_d   = 8'd0;
      end
    endcase

    // A request arriving on the serve cycle keeps the latch set for the next phase.
    if (w_serve && r_ped_pending && !w_hit) begin
      w_walk_cnt_d    = WalkLoad;
      w_ped_pending_d = ped_req;
    end

    // Conflict overrides every other transition.
    if (w_hit) begin
      w_state_d    = S_RED;
      w_cnt_d      = 8'd0;
      w_conflict_d = 1'b1;
    end

    if (w_state_d != S_GREEN) begin
      w_walk_cnt_d = 8'd0;
    end
    w_walk_d = (w_state_d == S_GREEN) && (w_walk_cnt_d != 8'd0);

    unique case (w_state_d)
      S_GREEN:  w_cross_light_d = 2'd1;
      S_YELLOW: w_cross_light_d = 2'd2;
      default:  w_cross_light_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RED;
      r_cnt         <= 8'd0;
      r_walk_cnt    <= 8'd0;
      r_armed       <= 1'b0;
      r_ped_pending <= 1'b0;
      r_conflict    <= 1'b0;
      r_walk        <= 1'b0;
      r_cross_light <= 2'd0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_walk_cnt    <= w_walk_cnt_d;
      r_armed       <= w_armed_d;
      r_ped_pending <= w_ped_pending_d;
      r_conflict    <= w_conflict_d;
      r_walk        <= w_walk_d;
      r_cross_light <= w_cross_light_d;
    end
  end

  assign cross_light     = r_cross_light;
  assign cross_time_left = r_cnt;
  assign walk            = r_walk;
  assign ped_pending     = r_ped_pending;
  assign conflict        = r_conflict;

endmodule

// File: tb/tb_cross_light_ctrl.sv
// Directed bench for cross_light_ctrl with default parameters.
module tb_cross_light_ctrl;

  logic       clk;
  logic       reset_n;
  logic [1:0] main_light;
  logic       ped_req;
  logic [1:0] cross_light;
  logic [7:0] cross_time_left;
  logic       walk;
  logic       ped_pending;
  logic       conflict;

  int total;
  int bad;

  cross_light_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .main_light      (main_light),
    .ped_req         (ped_req),
    .cross_light     (cross_light),
    .cross_time_left (cross_time_left),
    .walk            (walk),
    .ped_pending     (ped_pending),
    .conflict        (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    main_light = 2'd0;
    ped_req    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Expected light/counter k edges after the first red sample with armed set.
  function automatic logic [1:0] exp_light(int k);
    if (k <= 4) return 2'd0;
    if (k <= 44) return 2'd1;
    if (k <= 49) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [7:0] exp_cnt(int k);
    if (k <= 4) return 8'(4 - k);
    if (k <= 44) return 8'(44 - k);
    if (k <= 49) return 8'(49 - k);
    return 8'd0;
  endfunction

  task automatic test_reset();
    reset_n    = 1'b0;
    main_light = 2'd1;
    ped_req    = 1'b1;
    repeat (2) tick();
    total++;
    if (cross_light !== 2'd0) begin
      bad++; $display("FAIL reset_light got=%0d exp=0", cross_light);
    end
    total++;
    if (cross_time_left !== 8'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", cross_time_left);
    end
    total++;
    if (walk !== 1'b0) begin
      bad++; $display("FAIL reset_walk got=%0b exp=0", walk);
    end
    total++;
    if (ped_pending !== 1'b0) begin
      bad++; $display("FAIL reset_ped got=%0b exp=0", ped_pending);
    end
    total++;
    if (conflict !== 1'b0) begin
      bad++; $display("FAIL reset_conflict got=%0b exp=0", conflict);
    end
    do_reset();
  endtask

  task automatic test_normal();
    main_light = 2'd1;
    repeat (3) tick();
    main_light = 2'd0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      total++;
      if (cross_light !== exp_light(k) || cross_time_left !== exp_cnt(k)) begin
        bad++;
        $display("FAIL normal_k%0d got=%0d/%0d exp=%0d/%0d", k, cross_light, cross_time_left,
                 exp_light(k), exp_cnt(k));
      end
      total++;
      if (walk !== 1'b0 || conflict !== 1'b0) begin
        bad++; $display("FAIL normal_flags_k%0d got=%0b%0b exp=00", k, walk, conflict);
      end
    end
  endtask

  // hold=1 raises ped_req again on the clear->green transition cycle.
  task automatic test_ped_phase(input bit hold);
    logic exp_walk, exp_ped;
    main_light = 2'd1;
    ped_req    = 1'b1;
    tick();
    total++;
    if (ped_pending !== 1'b1) begin
      bad++; $display("FAIL ped_latch got=%0b exp=1", ped_pending);
    end
    ped_req = 1'b0;
    tick();
    main_light = 2'd0;
    for (int k = 1; k <= 55; k++) begin
      ped_req = (hold && k == 5);
      tick();
      ped_req  = 1'b0;
      exp_walk = (k >= 5 && k <= 24);
      exp_ped  = (k < 5) ? 1'b1 : hold;
      total++;
      if (walk !== exp_walk) begin
        bad++; $display("FAIL ped_walk_h%0b_k%0d got=%0b exp=%0b", hold, k, walk, exp_walk);
      end
      total++;
      if (ped_pending !== exp_ped) begin
        bad++; $display("FAIL ped_pend_h%0b_k%0d got=%0b exp=%0b", hold, k, ped_pending, exp_ped);
      end
    end
  endtask

  task automatic test_conflict_green();
    main_light = 2'd1;
    ped_req    = 1'b1;
    tick();
    ped_req    = 1'b0;
    main_light = 2'd0;
    repeat (24) tick();
    total++;
    if (cross_light !== 2'd1 || cross_time_left !== 8'd20 || walk !== 1'b1) begin
      bad++;
      $display("FAIL cg_pre got=%0d/%0d/%0b exp=1/20/1", cross_light, cross_time_left, walk);
    end
    main_light = 2'd1;
    tick();
    total++;
    if (cross_light !== 2'd0 || cross_time_left !== 8'd0 || walk !== 1'b0 || conflict !== 1'b1)
    begin
      bad++;
      $display("FAIL cg_hit got=%0d/%0d/%0b/%0b exp=0/0/0/1", cross_light, cross_time_left,
               walk, conflict);
    end
    for (int r = 0; r < 3; r++) begin
      main_light = 2'd1;
      tick();
      main_light = 2'd0;
      for (int k = 0; k < 12; k++) begin
        tick();
        total++;
        if (cross_light !== 2'd0 || cross_time_left !== 8'd0 || conflict !== 1'b1) begin
          bad++;
          $display("FAIL cg_lock_r%0d_k%0d got=%0d/%0d/%0b exp=0/0/1", r, k, cross_light,
                   cross_time_left, conflict);
        end
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    main_light = 2'd3;
    tick();
    total++;
    if (conflict !== 1'b0 || cross_light !== 2'd0) begin
      bad++; $display("FAIL ill_red got=%0b/%0d exp=0/0", conflict, cross_light);
    end
    main_light = 2'd0;
    tick();
    total++;
    if (cross_time_left !== 8'd3) begin
      bad++; $display("FAIL ill_armed got=%0d exp=3", cross_time_left);
    end
    tick();
    main_light = 2'd3;
    tick();
    total++;
    if (conflict !== 1'b1 || cross_light !== 2'd0 || cross_time_left !== 8'd0) begin
      bad++;
      $display("FAIL ill_hit got=%0b/%0d/%0d exp=1/0/0", conflict, cross_light, cross_time_left);
    end
    for (int i = 0; i < 60; i++) begin
      main_light = ((i % 20) < 2) ? 2'd1 : 2'd0;
      tick();
      total++;
      if (cross_light !== 2'd0 || cross_time_left !== 8'd0 || conflict !== 1'b1) begin
        bad++;
        $display("FAIL ill_lock_i%0d got=%0d/%0d/%0b exp=0/0/1", i, cross_light,
                 cross_time_left, conflict);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    main_light = 2'd1;
    tick();
    main_light = 2'd0;
    repeat (46) tick();
    total++;
    if (cross_light !== 2'd2 || cross_time_left !== 8'd3) begin
      bad++; $display("FAIL ar_pre got=%0d/%0d exp=2/3", cross_light, cross_time_left);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (cross_light !== 2'd0 || cross_time_left !== 8'd0 || walk !== 1'b0 ||
        ped_pending !== 1'b0 || conflict !== 1'b0) begin
      bad++;
      $display("FAIL ar_async got=%0d/%0d/%0b/%0b/%0b exp=0/0/0/0/0", cross_light,
               cross_time_left, walk, ped_pending, conflict);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      total++;
      if (cross_light !== 2'd0 || cross_time_left !== 8'd0) begin
        bad++;
        $display("FAIL ar_idle_i%0d got=%0d/%0d exp=0/0", i, cross_light, cross_time_left);
      end
    end
    main_light = 2'd2;
    tick();
    main_light = 2'd0;
    tick();
    total++;
    if (cross_light !== 2'd0 || cross_time_left !== 8'd3) begin
      bad++; $display("FAIL ar_rearm got=%0d/%0d exp=0/3", cross_light, cross_time_left);
    end
    repeat (4) tick();
    total++;
    if (cross_light !== 2'd1 || cross_time_left !== 8'd39) begin
      bad++; $display("FAIL ar_green got=%0d/%0d exp=1/39", cross_light, cross_time_left);
    end
  endtask

  // Main only leaves red after the cross phase has completed, so no conflict is expected.
  task automatic test_invariant();
    int cycles;
    int n;
    do_reset();
    cycles = 0;
    while (cycles < 2000) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        main_light = 2'($urandom_range(1, 3));
        ped_req    = 1'($urandom_range(0, 1));
        tick();
        cycles++;
      end
      n = $urandom_range(51, 70);
      for (int i = 0; i < n; i++) begin
        main_light = 2'd0;
        ped_req    = 1'($urandom_range(0, 1));
        tick();
        cycles++;
        total++;
        if (cross_time_left === 8'd255 || cross_light === 2'd3 || conflict !== 1'b0) begin
          bad++;
          $display("FAIL inv_c%0d got=%0d/%0d/%0b", cycles, cross_light, cross_time_left,
                   conflict);
        end
      end
    end
    ped_req = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    main_light = 2'd0;
    ped_req    = 1'b0;
    test_reset();
    test_normal();
    test_ped_phase(1'b0);
    test_ped_phase(1'b1);
    test_conflict_green();
    test_illegal();
    test_async_reset();
    test_invariant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
